// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating direction counters; lookup is combinational, updates happen on the clock edge.
// Ports: clk, rst (sync, active-high); lookup_pc -> hit, predict_taken, predict_target;
//        upd_valid, upd_pc, upd_taken, upd_target carry resolved-branch updates.
module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            hit,
  output logic            predict_taken,
  output logic [PC_W-1:0] predict_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] THR = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tags [ENTRIES];
  logic [PC_W-1:0] targets [ENTRIES];
  logic [CNT_W-1:0] cnt [ENTRIES];
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic u_hit;
  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[PC_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[PC_W-1:IDX_W+2];
  assign u_hit = valid[u_idx] && tags[u_idx] == u_tag;
  always_comb begin
    hit = valid[l_idx] && tags[l_idx] == l_tag;
    predict_taken = hit && cnt[l_idx] >= THR;
    predict_target = predict_taken ? targets[l_idx] : lookup_pc + PC_W'(4);
  end
  // Tags and targets are left unreset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= THR - CNT_W'(1);
    end else if (upd_valid) begin
      if (u_hit) begin
        cnt[u_idx] <= upd_taken ? (cnt[u_idx] == MAX ? MAX : cnt[u_idx] + CNT_W'(1))
                                : (cnt[u_idx] == '0 ? '0 : cnt[u_idx] - CNT_W'(1));
        if (upd_taken) targets[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid[u_idx] <= 1'b1;
        tags[u_idx] <= u_tag;
        targets[u_idx] <= upd_target;
        cnt[u_idx] <= THR;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed and randomized checks of branch_target_predictor against a behavioural table model.
module tb_branch_target_predictor;
  logic clk = 0, rst = 1;
  logic [31:0] lookup_pc = 0, upd_pc = 0, upd_target = 0;
  logic upd_valid = 0, upd_taken = 0;
  logic hit, predict_taken;
  logic [31:0] predict_target;
  int n_tests = 0, n_fail = 0;
  bit m_valid [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int m_cnt [16];
  branch_target_predictor dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .hit(hit),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 64;
  endfunction
  task automatic model_edge(input bit r, input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    int i;
    i = idx_of(upc);
    if (r) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0;
        m_cnt[k] = 1;
      end
    end else if (uv) begin
      if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
        if (ut) begin
          m_cnt[i] = m_cnt[i] < 3 ? m_cnt[i] + 1 : 3;
          m_tgt[i] = utgt;
        end else m_cnt[i] = m_cnt[i] > 0 ? m_cnt[i] - 1 : 0;
      end else if (ut) begin
        m_valid[i] = 1;
        m_tag[i] = tag_of(upc);
        m_tgt[i] = utgt;
        m_cnt[i] = 2;
      end
    end
  endtask
  task automatic step(input bit chk, input string tag, input logic [31:0] lpc, input bit r,
                      input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    int i;
    bit eh, et;
    @(negedge clk);
    lookup_pc = lpc;
    rst = r;
    upd_valid = uv;
    upd_pc = upc;
    upd_taken = ut;
    upd_target = utgt;
    #1;
    if (chk) begin
      i = idx_of(lpc);
      eh = m_valid[i] && m_tag[i] == tag_of(lpc);
      et = eh && m_cnt[i] >= 2;
      check({tag, ".hit"}, 32'(hit), 32'(eh));
      check({tag, ".taken"}, 32'(predict_taken), 32'(et));
      check({tag, ".target"}, predict_target, et ? m_tgt[i] : lpc + 32'd4);
    end
    @(posedge clk);
    model_edge(r, uv, upc, ut, utgt);
  endtask
  task automatic look(input string tag, input logic [31:0] lpc);
    step(1, tag, lpc, 0, 0, 0, 0, 0);
  endtask
  task automatic upd(input string tag, input logic [31:0] lpc, input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    step(1, tag, lpc, 0, 1, upc, ut, utgt);
  endtask
  initial begin
    logic [31:0] a, b;
    step(0, "rst", 32'h40, 1, 0, 0, 0, 0);
    step(0, "rst", 32'h40, 1, 0, 0, 0, 0);
    look("reset", 32'h40);
    check("reset.target_const", predict_target, 32'h44);
    upd("alloc_same_cycle", 32'h40, 32'h40, 1, 32'h100);
    look("alloc", 32'h40);
    check("alloc.target_const", predict_target, 32'h100);
    for (int k = 0; k < 3; k++) upd("sat_up", 32'h40, 32'h40, 1, 32'h100);
    upd("sat_dn", 32'h40, 32'h40, 0, 32'h0);
    upd("sat_dn", 32'h40, 32'h40, 0, 32'h0);
    look("weak_nt", 32'h40);
    check("weak_nt.target_const", predict_target, 32'h44);
    look("alias_miss", 32'h440);
    upd("alias_upd", 32'h440, 32'h440, 1, 32'h200);
    look("alias_hit", 32'h440);
    check("alias_hit.target_const", predict_target, 32'h200);
    look("alias_evicted", 32'h40);
    upd("nt_miss", 32'h80, 32'h80, 0, 32'h300);
    look("nt_miss", 32'h80);
    look("wrap", 32'hFFFF_FFFC);
    check("wrap.target_const", predict_target, 32'h0);
    step(1, "rst_upd", 32'h440, 1, 1, 32'h40, 1, 32'h500);
    look("rst_upd_40", 32'h40);
    look("rst_upd_440", 32'h440);
    for (int k = 0; k < 600; k++) begin
      a = {$urandom_range(0, 2) == 0 ? 26'h3FF_FFFF : 26'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      b = {26'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      step(1, "rand", $urandom_range(0, 1) ? a : b, $urandom_range(0, 60) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) ? a : b, $urandom_range(0, 2) != 0, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL provide parameter ENTRIES, default 16, number of table entries (power of two, ≥2).
REQ-002 SHALL provide parameter PC_W, default 32, PC width in bits.
REQ-003 SHALL provide parameter CNT_W, default 2, width of the saturating direction counter (≥1).
REQ-004 SHALL provide port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL provide port lookup_pc, input, PC_W, fetch-stage PC to predict.
REQ-007 SHALL provide port hit, output, 1, valid entry with matching tag for lookup_pc.
REQ-008 SHALL provide port predict_taken, output, 1, predicted direction.
REQ-009 SHALL provide port predict_target, output, PC_W, predicted next PC.
REQ-010 SHALL provide port upd_valid, input, 1, resolved-branch update strobe from decode.
REQ-011 SHALL provide port upd_pc, input, PC_W, PC of the resolved branch.
REQ-012 SHALL provide port upd_taken, input, 1, resolved direction.
REQ-013 SHALL provide port upd_target, input, PC_W, resolved taken target.

Function
REQ-014 SHALL derive, with IDX_W = log2(ENTRIES): index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-015 SHALL store per entry: valid bit, tag, target (PC_W), counter (CNT_W).
REQ-016 SHALL make lookup purely combinational, zero latency, same cycle as lookup_pc: hit = valid[index] & (tag[index] == tag(lookup_pc)).
REQ-017 SHALL use THR = 2^(CNT_W-1) as threshold: predict_taken = hit & (counter ≥ THR).
REQ-018 SHALL drive predict_target = stored target when predict_taken, else lookup_pc + 4 (modulo 2^PC_W, wrap allowed).
REQ-019 SHALL process the update on the clock edge when upd_valid=1 and rst=0; upd_valid=0 leaves the table unchanged.
REQ-020 SHALL, on an update hit (valid & tag match): taken → counter+1, saturating at 2^CNT_W-1, target := upd_target; not-taken → counter-1, saturating at 0, target unchanged.
REQ-021 SHALL, on an update miss with upd_taken=1: allocate/replace the indexed entry (valid:=1, tag, target := upd_target, counter := THR); any aliasing entry is overwritten.
REQ-022 SHALL, on an update miss with upd_taken=0, not allocate; the table stays unchanged.
REQ-023 SHALL NOT bypass a same-cycle update to the lookup port; lookup reflects contents before the edge, and the new contents are visible from the next cycle.
REQ-024 SHALL let at most one entry change per cycle; the update port has no backpressure.

Reset
REQ-025 SHALL, on rst=1 at an edge, clear all valid bits and set all counters to THR-1; tags and targets are don't-care.
REQ-026 SHALL give rst priority over a simultaneous upd_valid; the update is discarded.
REQ-027 SHALL make outputs after reset follow from the cleared table: hit=0, predict_taken=0, predict_target=lookup_pc+4.

Verification (ENTRIES=16, PC_W=32, CNT_W=2)
REQ-028 SHALL cover reset: after reset, lookup_pc=0x00000040 → hit=0, predict_taken=0, predict_target=0x00000044.
REQ-029 SHALL cover allocation: update pc=0x40, taken, target=0x100; next cycle lookup 0x40 → hit=1, predict_taken=1, predict_target=0x100.
REQ-030 SHALL cover saturation: after REQ-029, 3 more taken updates (counter 11), then 2 not-taken updates → counter 01; lookup 0x40 → hit=1, predict_taken=0, predict_target=0x44.
REQ-031 SHALL cover aliasing: entry 0x40 allocated; lookup 0x440 (index 0, tag 0x11) → hit=0; update 0x440 taken, target=0x200 → lookup 0x440 hit, target 0x200; lookup 0x40 → hit=0.
REQ-032 SHALL cover not-taken miss: update 0x80, not-taken → lookup 0x80 hit=0.
REQ-033 SHALL cover simultaneous events: update 0x40 taken while lookup 0x40 in the same cycle → that cycle hit=0, next cycle hit=1; rst=1 together with upd_valid=1 → table cleared, no allocation.
